pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised pipeline-register chain that replaces ad-hoc combinational zeroing of pipeline latches with clocked, per-stage clearing.
- Carries a data word plus destination-register tag through STAGES registered stages.
- Supports per-stage stall and flush, valid tracking, and a post-reset init hold.
- Instantiated between datapath stages, e.g. EX->MEM->WB, one instance per bundle.

Parameters:
- DATA_W, 32: width of data payload.
- TAG_W, 5: width of destination-register tag.
- STAGES, 3: number of register stages (>=1).
- HOLD_CYCLES, 2: cycles held in INIT after reset release before accepting input (>=1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  input entry valid
- in_data  in  DATA_W  input payload
- in_tag  in  TAG_W  input destination tag
- stall  in  STAGES  stall[k] holds stage k
- flush  in  STAGES  flush[k] invalidates stage k
- out_valid  out  1  valid of last stage
- out_data  out  DATA_W  last-stage payload
- out_tag  out  TAG_W  last-stage tag
- ready  out  1  chain accepting input (state RUN and stage 0 not held)
- occupancy  out  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset (reset==0 at rising edge): all stage valid/data/tag = 0; FSM -> INIT; init counter = 0; ready = 0; occupancy = 0.
  - Reset has priority over stall, flush, and input.
  - Reset mid-operation discards all in-flight entries on that edge.
- FSM states:
  - INIT: counter increments each cycle; in_valid ignored, so stage 0 loads a bubble. After HOLD_CYCLES cycles in INIT -> RUN.
  - RUN: normal operation; stays in RUN until reset.
- Hold propagation: hold[k] = OR of stall[j] for j>=k. A stall freezes its own stage and every upstream stage.
- Per-stage update, in priority order:
  1. flush[k]: valid=0, data=0, tag=0. Flush beats hold; a flushed, held stage becomes a bubble.
  2. hold[k]: retain contents.
  3. Otherwise load from stage k-1. Stage 0 loads from the inputs when in RUN.
     - If stage k-1 is held, or its valid is 0, stage k loads a bubble.
- Bubbles always carry data=0 and tag=0. out_data and out_tag are 0 whenever out_valid=0.
- An entry accepted with in_valid=1 while ready=1 is accepted. in_valid while ready=0 is dropped.
- Latency: with no stall or flush, input at edge N appears on the outputs after edge N+STAGES-1 (STAGES register delays).
- occupancy is registered-consistent: combinational popcount of stage valids, range 0..STAGES.
- Simultaneous flush[k] and in_valid with STAGES==1: flush wins and the input is dropped.
- No wrap-around. Counters saturate, and the init counter stops once RUN is reached.

Optional Feature:
- Macro: PIPE_FLUSH_STATS_EN.
- Defined:
  - Adds output flush_count (16 bits).
  - Increments by the number of valid entries destroyed by flush on each edge, saturating at 16'hFFFF.
  - Clears on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then release: reset=0 for 2 cycles, then 1 -> ready=0 for exactly 2 cycles (HOLD_CYCLES=2), then 1; all outputs 0 throughout.
- Streaming, no stalls: in_data=32'hA5A5_0001, tag=5'd7, in_valid=1 for one cycle -> out_valid=1, out_data=32'hA5A5_0001, out_tag=7 after exactly 3 edges; occupancy goes 1,1,1 then 0.
- Stall: stall=3'b010 held 2 cycles with entries in stages 0 and 1 -> stages 0,1 frozen; stage 2 receives bubbles (out_valid=0, out_data=0); ready=0; entries resume unchanged after stall drops.
- Flush vs stall: flush[1]=1 and stall[1]=1 same cycle with a valid entry in stage 1 -> stage 1 becomes bubble next edge; occupancy decrements by 1; with PIPE_FLUSH_STATS_EN, flush_count 0 -> 1.
- Reset mid-operation: 3 valid entries in flight, assert reset=0 one cycle -> next edge occupancy=0, out_valid=0, ready=0, FSM re-enters INIT.
- Input during INIT: in_valid=1, in_data=32'hDEAD_BEEF while ready=0 -> entry never appears at output; occupancy stays 0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   A parametrised chain of pipeline registers. It carries a data word and a
//   destination-register tag through STAGES clocked stages. Each stage can be
//   stalled or flushed on its own, and stage valids are tracked. After reset
//   the chain waits HOLD_CYCLES cycles in INIT before it accepts input.
//   Invalid stages always hold data=0 and tag=0, so the outputs read as zero
//   whenever out_valid is low.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   in_valid     input entry valid
//   in_data      input payload (DATA_W)
//   in_tag       input destination tag (TAG_W)
//   stall        stall[k] holds stage k and every stage upstream of it
//   flush        flush[k] turns stage k into a bubble (beats stall)
//   out_valid    valid of the last stage
//   out_data     payload of the last stage
//   out_tag      tag of the last stage
//   ready        chain accepts input (RUN and stage 0 not held)
//   occupancy    number of valid stages
//   flush_count  (only with PIPE_FLUSH_STATS_EN) saturating count of valid
//                entries destroyed by flush
//
// Optional feature macro: PIPE_FLUSH_STATS_EN

module pipe_reg_chain #(
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 5,
   parameter int STAGES      = 3,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   input  logic [TAG_W-1:0]              in_tag,
   input  logic [STAGES-1:0]             stall,
   input  logic [STAGES-1:0]             flush,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [TAG_W-1:0]              out_tag,
   output logic                          ready,
   output logic [$clog2(STAGES+1)-1:0]   occupancy
`ifdef PIPE_FLUSH_STATS_EN
   ,
   output logic [15:0]                   flush_count
`endif
);

   localparam int OCC_W = $clog2(STAGES+1);
   localparam int CNT_W = $clog2(HOLD_CYCLES+1);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t              state, next_state;
   logic [CNT_W-1:0]    init_count;
   logic [STAGES-1:0]   hold;
   logic [STAGES-1:0]   valid_q, valid_d;
   logic [DATA_W-1:0]   data_q [STAGES];
   logic [DATA_W-1:0]   data_d [STAGES];
   logic [TAG_W-1:0]    tag_q  [STAGES];
   logic [TAG_W-1:0]    tag_d  [STAGES];
   logic [OCC_W-1:0]    occ_sum;

   always_ff @(posedge clock) begin
      if (!reset) state <= INIT;
      else        state <= next_state;
   end

   // The last INIT cycle is the one in which the counter reaches HOLD_CYCLES-1.
   always_comb begin
      next_state = state;
      if (state == INIT && init_count == CNT_W'(HOLD_CYCLES-1))
         next_state = RUN;
   end

   // The counter only advances in INIT, so it freezes once RUN is reached.
   always_ff @(posedge clock) begin
      if (!reset)              init_count <= '0;
      else if (state == INIT)  init_count <= init_count + CNT_W'(1);
   end

   // A stall anywhere downstream also freezes every upstream stage.
   always_comb begin
      hold = '0;
      hold[STAGES-1] = stall[STAGES-1];
      for (int k = STAGES-2; k >= 0; k--)
         hold[k] = stall[k] | hold[k+1];
   end

   assign ready = (state == RUN) && !hold[0];

   // Per-stage next value. Flush beats hold, and hold beats load. A stage
   // behind a held neighbour receives a bubble, because the entry in that
   // neighbour has not moved.
   always_comb begin
      valid_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         data_d[k] = '0;
         tag_d[k]  = '0;
      end
      if (!flush[0]) begin
         if (hold[0]) begin
            valid_d[0] = valid_q[0];
            data_d[0]  = data_q[0];
            tag_d[0]   = tag_q[0];
         end else if (ready && in_valid) begin
            valid_d[0] = 1'b1;
            data_d[0]  = in_data;
            tag_d[0]   = in_tag;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (!flush[k]) begin
            if (hold[k]) begin
               valid_d[k] = valid_q[k];
               data_d[k]  = data_q[k];
               tag_d[k]   = tag_q[k];
            end else if (!hold[k-1] && valid_q[k-1]) begin
               valid_d[k] = 1'b1;
               data_d[k]  = data_q[k-1];
               tag_d[k]   = tag_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
            tag_q[k]  <= tag_d[k];
         end
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < STAGES; k++)
         occ_sum = occ_sum + OCC_W'(valid_q[k]);
   end

   assign occupancy = occ_sum;
   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];

`ifdef PIPE_FLUSH_STATS_EN
   logic [OCC_W-1:0] flush_lost;
   logic [16:0]      flush_sum;

   // Only stages that hold a valid entry count as lost when flushed.
   always_comb begin
      flush_lost = '0;
      for (int k = 0; k < STAGES; k++)
         flush_lost = flush_lost + OCC_W'(flush[k] & valid_q[k]);
      flush_sum = {1'b0, flush_count} + 17'(flush_lost);
   end

   always_ff @(posedge clock) begin
      if (!reset) flush_count <= '0;
      else        flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain
//   Drives pipe_reg_chain with directed scenarios and then with random
//   traffic. Every output is compared against a behavioural model of the
//   stage contents, which the bench keeps itself.

module tb_pipe_reg_chain;

   localparam int S    = 3;
   localparam int HOLD = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic [4:0]  in_tag;
   logic [S-1:0] stall;
   logic [S-1:0] flush;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        ready;
   logic [1:0]  occupancy;
`ifdef PIPE_FLUSH_STATS_EN
   logic [15:0] flush_count;
`endif

   pipe_reg_chain #(.DATA_W(32), .TAG_W(5), .STAGES(S), .HOLD_CYCLES(HOLD)) dut (
      .clock(clock),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_tag(in_tag),
      .stall(stall),
      .flush(flush),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_tag(out_tag),
      .ready(ready),
      .occupancy(occupancy)
`ifdef PIPE_FLUSH_STATS_EN
      ,
      .flush_count(flush_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic [4:0]  t;
   } entry_t;

   entry_t m_stage [S];
   int     init_left;
   int     m_flushes;
   int     total = 0;
   int     bad   = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int modelOccupancy();
      int n = 0;
      for (int k = 0; k < S; k++) n += int'(m_stage[k].v);
      return n;
   endfunction

   // The model treats the chain as a row of slots. Everything at or below the
   // highest stalled index stays put, and the slot just after it gets a gap.
   // Everything beyond that gap shifts forward by one. A flush then blanks
   // the chosen slots.
   task automatic modelAdvance();
      entry_t nxt [S];
      int h;
      if (!reset) begin
         for (int k = 0; k < S; k++) m_stage[k] = '0;
         init_left = HOLD;
         m_flushes = 0;
         return;
      end
      h = -1;
      for (int k = 0; k < S; k++) if (stall[k]) h = k;
      for (int k = 0; k < S; k++) begin
         if (k <= h)
            nxt[k] = m_stage[k];
         else if (k == h + 1) begin
            if (k == 0 && init_left == 0 && in_valid)
               nxt[k] = {1'b1, in_data, in_tag};
            else
               nxt[k] = '0;
         end else
            nxt[k] = m_stage[k-1];
      end
      for (int k = 0; k < S; k++) begin
         if (flush[k]) begin
            if (m_stage[k].v) m_flushes++;
            nxt[k] = '0;
         end
      end
      if (m_flushes > 65535) m_flushes = 65535;
      if (init_left > 0) init_left--;
      for (int k = 0; k < S; k++) m_stage[k] = nxt[k];
   endtask

   task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] d,
                                input logic [4:0] t, input logic [S-1:0] st, input logic [S-1:0] fl);
      reset    = rst;
      in_valid = iv;
      in_data  = d;
      in_tag   = t;
      stall    = st;
      flush    = fl;
      #1;
      checkOutput("out_valid", 64'(out_valid), 64'(m_stage[S-1].v));
      checkOutput("out_data",  64'(out_data),  64'(m_stage[S-1].d));
      checkOutput("out_tag",   64'(out_tag),   64'(m_stage[S-1].t));
      checkOutput("ready",     64'(ready),     64'(init_left == 0 && st == '0));
      checkOutput("occupancy", 64'(occupancy), 64'(modelOccupancy()));
`ifdef PIPE_FLUSH_STATS_EN
      checkOutput("flush_count", 64'(flush_count), 64'(m_flushes));
`endif
      modelAdvance();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, 5'h0, '0, '0);
   endtask

   initial begin
      logic [S-1:0] st, fl;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; stall = '0; flush = '0;
      // The first reset edge brings the DUT out of its unknown power-up state.
      @(posedge clock);
      #1;
      modelAdvance();
      applyStimulus(1'b0, 1'b0, 32'h0, 5'h0, '0, '0);
      idle(4);

      // A single streamed entry.
      applyStimulus(1'b1, 1'b1, 32'hA5A5_0001, 5'd7, '0, '0);
      idle(4);

      // Two entries, then a stall on the middle stage for two cycles.
      applyStimulus(1'b1, 1'b1, 32'h1111_0001, 5'd1, '0, '0);
      applyStimulus(1'b1, 1'b1, 32'h2222_0002, 5'd2, '0, '0);
      applyStimulus(1'b1, 1'b0, 32'h0, 5'h0, 3'b010, '0);
      applyStimulus(1'b1, 1'b0, 32'h0, 5'h0, 3'b010, '0);
      idle(4);

      // Flush and stall land on the same stage together.
      applyStimulus(1'b1, 1'b1, 32'h3333_0003, 5'd3, '0, '0);
      applyStimulus(1'b1, 1'b0, 32'h0, 5'h0, '0, '0);
      applyStimulus(1'b1, 1'b0, 32'h0, 5'h0, 3'b010, 3'b010);
      idle(4);

      // Reset with the chain full, then input offered while still in INIT.
      applyStimulus(1'b1, 1'b1, 32'h4444_0004, 5'd4, '0, '0);
      applyStimulus(1'b1, 1'b1, 32'h5555_0005, 5'd5, '0, '0);
      applyStimulus(1'b1, 1'b1, 32'h6666_0006, 5'd6, '0, '0);
      applyStimulus(1'b0, 1'b1, 32'h7777_0007, 5'd8, '0, '0);
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd9, '0, '0);
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd9, '0, '0);
      idle(4);

      // Random traffic with occasional stalls, flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < S; k++) begin
            st[k] = ($urandom_range(0, 5) == 0);
            fl[k] = ($urandom_range(0, 9) == 0);
         end
         applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                       32'($urandom()), 5'($urandom_range(0, 31)), st, fl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
